// File: rtl/maze_map_mem.sv
// Maze map memory: 16x16 grid of wall and visited bits. Walls are loaded row by
// row through a valid/ready port; the solver reads "blocked" and writes visited.
module maze_map_mem #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_start,
    input  logic                         ld_valid,
    input  logic [2**COL_BITS-1:0]       ld_row,
    output logic                         ld_ready,
    output logic                         ld_done,
    input  logic                         clr_start,
    output logic                         busy,
    input  logic [ROW_BITS+COL_BITS-1:0] addr,
    input  logic                         rd,
    input  logic                         wr,
    input  logic                         din,
    output logic                         dout
);

    localparam int ROWS = 2**ROW_BITS;
    localparam int COLS = 2**COL_BITS;
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_CLEAR
    } state_e;

    state_e              state_q, state_d;
    logic [ROW_BITS-1:0] cnt_q, cnt_d;
    logic                ld_done_q, ld_done_d;
    logic [COLS-1:0]     wall_q [ROWS];
    logic [COLS-1:0]     visit_q [ROWS];

    logic                accept;
    logic [ROW_BITS-1:0] row_sel;
    logic [COL_BITS-1:0] col_sel;

    assign row_sel  = addr[ROW_BITS+COL_BITS-1:COL_BITS];
    assign col_sel  = addr[COL_BITS-1:0];
    assign ld_ready = (state_q == S_LOAD);
    assign busy     = (state_q == S_LOAD) || (state_q == S_CLEAR);
    assign accept   = ld_valid && ld_ready;
    assign ld_done  = ld_done_q;

    // Read path: zero latency, and fail-safe "blocked" while the map is in flux.
    assign dout = rd && (busy || wall_q[row_sel][col_sel] || visit_q[row_sel][col_sel]);

    // Next-state logic for the load/clear sequencer and its row counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ld_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (cnt_q == LAST_ROW) begin
                        state_d   = S_READY;
                        ld_done_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + ROW_BITS'(1);
                    end
                end
            end
            S_READY: begin
                // A simultaneous load request takes priority over a clear request.
                if (ld_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else if (clr_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == LAST_ROW) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ROW_BITS'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state, row counter and the registered ld_done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ld_done_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values, regardless of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_done_q <= ld_done_d;
        end
    end

    // Map storage: row loads, row-by-row visited clear, and solver visited writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the map is held in flops and reset explicitly, because a reset
            // must discard any partial load and leave every cell reading open.
            for (int r = 0; r < ROWS; r++) begin
                wall_q[r]  <= '0;
                visit_q[r] <= '0;
            end
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        wall_q[cnt_q]  <= ld_row;
                        visit_q[cnt_q] <= '0;
                    end
                end
                S_CLEAR: visit_q[cnt_q] <= '0;
                S_READY: begin
                    if (wr) begin
                        visit_q[row_sel][col_sel] <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_map_mem.sv
// Directed testbench for maze_map_mem: load, read, visited write, clear,
// stalled load, fail-safe reads while busy, and reset in the middle of a load.
module tb_maze_map_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_row = '0;
    logic        ld_ready;
    logic        ld_done;
    logic        clr_start = 1'b0;
    logic        busy;
    logic [7:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        din = 1'b0;
    logic        dout;

    int checks = 0;
    int errors = 0;

    maze_map_mem #(.ROW_BITS(4), .COL_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_row    (ld_row),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .clr_start (clr_start),
        .busy      (busy),
        .addr      (addr),
        .rd        (rd),
        .wr        (wr),
        .din       (din),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    // Move to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational read of one cell, compared in the same cycle.
    task automatic read_cell(input string name, input logic [7:0] a, input logic exp);
        addr = a;
        rd   = 1'b1;
        #1;
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL %s addr=%h dout=%b expected=%b", name, a, dout, exp);
        end
        rd = 1'b0;
    endtask

    // Full load with ld_valid held high; checks ld_ready and the ld_done pulse.
    task automatic load_map(input logic [15:0] rows [16]);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1;
            ld_row   = rows[i];
            #1;
            checks++;
            if (ld_ready !== 1'b1 || ld_done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL load_row%0d ready=%b done=%b busy=%b expected 1 0 1",
                         i, ld_ready, ld_done, busy);
            end
            tick();
        end
        ld_valid = 1'b0;
        ld_row   = '0;
        checks++;
        if (ld_done !== 1'b1 || busy !== 1'b0 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_done done=%b busy=%b ready=%b expected 1 0 0",
                     ld_done, busy, ld_ready);
        end
        tick();
        checks++;
        if (ld_done !== 1'b0) begin
            errors++;
            $display("FAIL load_done_pulse done=%b expected 0", ld_done);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (ld_ready !== 1'b0 || ld_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b done=%b busy=%b expected 0 0 0",
                     ld_ready, ld_done, busy);
        end
        read_cell("reset_read", 8'hFF, 1'b0);
        #4 rst = 1'b1;
        tick();
        // IDLE ignores ld_valid without ld_start.
        ld_valid = 1'b1;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready ready=%b expected 0", ld_ready);
        end
        ld_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_zero();
        logic [15:0] rows [16];
        for (int i = 0; i < 16; i++) rows[i] = 16'h0000;
        load_map(rows);
        read_cell("zero_00", 8'h00, 1'b0);
        read_cell("zero_ff", 8'hFF, 1'b0);
    endtask

    task automatic test_wall_read();
        logic [15:0] rows [16];
        for (int i = 0; i < 16; i++) rows[i] = 16'h0000;
        rows[3] = 16'h0010;
        load_map(rows);
        read_cell("wall_34", 8'h34, 1'b1);
        read_cell("wall_35", 8'h35, 1'b0);
        read_cell("wall_43", 8'h43, 1'b0);
        addr = 8'h34;
        rd   = 1'b0;
        #1;
        checks++;
        if (dout !== 1'b0) begin
            errors++;
            $display("FAIL rd_low dout=%b expected 0", dout);
        end
        tick();
    endtask

    task automatic test_visit_clear();
        int busy_cycles;
        addr = 8'h12; wr = 1'b1; din = 1'b1;
        tick();
        wr = 1'b0;
        read_cell("visit_12", 8'h12, 1'b1);
        // Same-cycle read and write: read shows the pre-write value.
        addr = 8'h56; wr = 1'b1; din = 1'b1; rd = 1'b1;
        #1;
        checks++;
        if (dout !== 1'b0) begin
            errors++;
            $display("FAIL rw_same_cycle dout=%b expected 0", dout);
        end
        tick();
        wr = 1'b0; rd = 1'b0;
        read_cell("visit_56", 8'h56, 1'b1);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            busy_cycles++;
            tick();
        end
        checks++;
        if (busy_cycles != 16) begin
            errors++;
            $display("FAIL clear_busy_cycles got=%0d expected=16", busy_cycles);
        end
        checks++;
        if (ld_done !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_done done=%b expected 0", ld_done);
        end
        read_cell("clear_12", 8'h12, 1'b0);
        read_cell("clear_56", 8'h56, 1'b0);
        read_cell("clear_wall_34", 8'h34, 1'b1);
        tick();
    endtask

    task automatic test_stall_load();
        int accepted;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        accepted = 0;
        for (int c = 0; c < 40 && accepted < 16; c++) begin
            ld_valid = c[0] == 1'b0;
            ld_row   = 16'h0001 << accepted;
            #1;
            checks++;
            if (ld_done !== 1'b0) begin
                errors++;
                $display("FAIL stall_early_done cycle=%0d done=%b expected 0", c, ld_done);
            end
            if (ld_valid && ld_ready) accepted++;
            tick();
        end
        ld_valid = 1'b0;
        checks++;
        if (ld_done !== 1'b1 || accepted != 16) begin
            errors++;
            $display("FAIL stall_done done=%b accepted=%0d expected 1 16", ld_done, accepted);
        end
        tick();
        read_cell("stall_00", 8'h00, 1'b1);
        read_cell("stall_55", 8'h55, 1'b1);
        read_cell("stall_56", 8'h56, 1'b0);
        read_cell("stall_ff", 8'hFF, 1'b1);
        read_cell("stall_fe", 8'hFE, 1'b0);
        read_cell("stall_34", 8'h34, 1'b0);
    endtask

    task automatic test_busy_fail_safe();
        // Load: accept row 0, then stall and attempt a solver write into row 0.
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_row = 16'h0000;
        tick();
        ld_valid = 1'b0;
        read_cell("load_failsafe_80", 8'h80, 1'b1);
        addr = 8'h03; wr = 1'b1; din = 1'b1;
        tick();
        wr = 1'b0;
        ld_valid = 1'b1;
        for (int i = 1; i < 16; i++) tick();
        ld_valid = 1'b0;
        tick();
        read_cell("load_wr_ignored", 8'h03, 1'b0);
        // Clear: write to row 0 during the last clear cycle, after row 0 is cleared.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        read_cell("clear_failsafe_77", 8'h77, 1'b1);
        addr = 8'h05; wr = 1'b1; din = 1'b1;
        tick();
        wr = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_end busy=%b expected 0", busy);
        end
        read_cell("clear_wr_ignored", 8'h05, 1'b0);
        // ld_start and clr_start together: load wins.
        ld_start = 1'b1; clr_start = 1'b1;
        tick();
        ld_start = 1'b0; clr_start = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_priority ready=%b busy=%b expected 1 1", ld_ready, busy);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] rows [16];
        // Still in LOAD from the previous task: start over with all-wall rows.
        rst = 1'b0;
        #2 rst = 1'b1;
        tick();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_row = 16'hFFFF;
        for (int i = 0; i < 7; i++) tick();
        ld_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b0 || busy !== 1'b0 || ld_done !== 1'b0) begin
            errors++;
            $display("FAIL midload_reset ready=%b busy=%b done=%b expected 0 0 0",
                     ld_ready, busy, ld_done);
        end
        read_cell("midload_reset_00", 8'h00, 1'b0);
        read_cell("midload_reset_6f", 8'h6F, 1'b0);
        #1 rst = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) rows[i] = 16'h0000;
        load_map(rows);
        read_cell("reload_00", 8'h00, 1'b0);
        read_cell("reload_35", 8'h35, 1'b0);
        read_cell("reload_6f", 8'h6F, 1'b0);
        read_cell("reload_ff", 8'hFF, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_zero();
        test_wall_read();
        test_visit_clear();
        test_stall_load();
        test_busy_fail_safe();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound the whole run so it always terminates.
    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
